rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 81 ++++++++
 tb/tb_rom_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin read arbiter in front of a registered single-port ROM
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req<n>, i_addr<n>       port n read request and address
//   o_gnt<n>                  port n request accepted (one-cycle pulse)
//   o_rvalid<n>, o_rdata<n>   port n read data valid pulse and held read data
//   o_rom_en, o_rom_addr      ROM read strobe and address (registered ROM returns data next cycle)
//   i_rom_data                ROM read data
//   o_busy                    high while a read is in flight
module rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic prio, owner, win1;
  // port 1 wins when it is the only requester or when both request and it holds priority
  assign win1 = i_req1 & (~i_req0 | prio);
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
    end else begin
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      case (state)
        IDLE: if (i_req0 | i_req1) begin
          state      <= ISSUE;
          owner      <= win1;
          prio       <= ~win1;
          o_gnt0     <= ~win1;
          o_gnt1     <= win1;
          o_rom_en   <= 1'b1;
          o_rom_addr <= win1 ? i_addr1 : i_addr0;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          state <= IDLE;
          if (owner) begin
            o_rdata1  <= i_rom_data;
            o_rvalid1 <= 1'b1;
          end else begin
            o_rdata0  <= i_rom_data;
            o_rvalid0 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a registered ROM model rom[a] = a ^ 8'hA5
module tb_rom_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, rom_en, busy;
  logic [7:0] rdata0, rdata1, rom_addr;
  logic [7:0] rom_data = '0;
  int         total = 0, passed = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (rom_en) rom_data <= rom_addr ^ 8'hA5;

  rom_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
    .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
    .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_en, rom_addr, busy} !== 30'h0)
        $display("FAIL reset_idle cycle %0d: got %h want 0", i,
                 {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_en, rom_addr, busy});
      else passed++;
    end
  endtask

  task automatic test_port0();
    do_reset();
    req0 = 1'b1;
    addr0 = 8'h10;
    tick();
    total++;
    if ({gnt0, gnt1, rom_en, rom_addr, busy} !== {3'b101, 8'h10, 1'b1})
      $display("FAIL p0_issue: got %b want %b", {gnt0, gnt1, rom_en, rom_addr, busy}, {3'b101, 8'h10, 1'b1});
    else passed++;
    req0 = 1'b0;
    tick();
    total++;
    if ({gnt0, rom_en, rom_addr, busy, rvalid0} !== {2'b00, 8'h00, 2'b10})
      $display("FAIL p0_wait: got %b want %b", {gnt0, rom_en, rom_addr, busy, rvalid0}, {2'b00, 8'h00, 2'b10});
    else passed++;
    tick();
    total++;
    if ({rvalid0, rdata0, busy, rvalid1, rdata1, gnt1} !== {1'b1, 8'hB5, 2'b00, 8'h00, 1'b0})
      $display("FAIL p0_rvalid: got %h want %h", {rvalid0, rdata0, busy, rvalid1, rdata1, gnt1},
               {1'b1, 8'hB5, 2'b00, 8'h00, 1'b0});
    else passed++;
    tick();
    total++;
    if ({rvalid0, rdata0} !== {1'b0, 8'hB5})
      $display("FAIL p0_hold: got %h want %h", {rvalid0, rdata0}, {1'b0, 8'hB5});
    else passed++;
  endtask

  task automatic test_both();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    addr0 = 8'h01;
    addr1 = 8'h02;
    tick();
    total++;
    if ({gnt0, gnt1, rom_addr} !== {2'b10, 8'h01})
      $display("FAIL both_first_gnt: got %h want %h", {gnt0, gnt1, rom_addr}, {2'b10, 8'h01});
    else passed++;
    req0 = 1'b0;
    tick();
    tick();
    total++;
    if ({rvalid0, rdata0, gnt1} !== {1'b1, 8'hA4, 1'b0})
      $display("FAIL both_rdata0: got %h want %h", {rvalid0, rdata0, gnt1}, {1'b1, 8'hA4, 1'b0});
    else passed++;
    tick();
    total++;
    if ({gnt0, gnt1, rom_addr} !== {2'b01, 8'h02})
      $display("FAIL both_second_gnt: got %h want %h", {gnt0, gnt1, rom_addr}, {2'b01, 8'h02});
    else passed++;
    req1 = 1'b0;
    tick();
    tick();
    total++;
    if ({rvalid1, rdata1, rvalid0, rdata0} !== {1'b1, 8'hA7, 1'b0, 8'hA4})
      $display("FAIL both_rdata1: got %h want %h", {rvalid1, rdata1, rvalid0, rdata0}, {1'b1, 8'hA7, 1'b0, 8'hA4});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_reset();
    addr0 = 8'h20;
    addr1 = 8'h21;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = (i % 2 == 0) ? addr0 ^ 8'hA5 : addr1 ^ 8'hA5;
      total++;
      if ({gnt0, gnt1, rom_en, rom_addr} !== {(i % 2 == 0), (i % 2 == 1), 1'b1, exp ^ 8'hA5})
        $display("FAIL b2b_gnt %0d: got %b want %b", i, {gnt0, gnt1, rom_en, rom_addr},
                 {(i % 2 == 0), (i % 2 == 1), 1'b1, exp ^ 8'hA5});
      else passed++;
      if (i % 2 == 0) addr0 = 8'h40 + 8'(i * 7);
      else addr1 = 8'h80 + 8'(i * 5);
      tick();
      tick();
      total++;
      if (i % 2 == 0 ? {rvalid0, rvalid1, rdata0} !== {2'b10, exp} : {rvalid0, rvalid1, rdata1} !== {2'b01, exp})
        $display("FAIL b2b_rdata %0d: got rv=%b%b d0=%h d1=%h want %h", i, rvalid0, rvalid1, rdata0, rdata1, exp);
      else passed++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_wait();
    do_reset();
    req1 = 1'b1;
    addr1 = 8'h33;
    tick();
    req1 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({rvalid1, rdata1, busy} !== {1'b0, 8'h00, 1'b0})
      $display("FAIL rst_wait_abort: got %h want 0", {rvalid1, rdata1, busy});
    else passed++;
    tick();
    total++;
    if ({rvalid1, rdata1} !== 9'h0)
      $display("FAIL rst_wait_norvalid: got %h want 0", {rvalid1, rdata1});
    else passed++;
    req0 = 1'b1;
    req1 = 1'b1;
    addr0 = 8'h44;
    addr1 = 8'h55;
    tick();
    total++;
    if ({gnt0, gnt1, rom_addr} !== {2'b10, 8'h44})
      $display("FAIL rst_wait_prio: got %h want %h", {gnt0, gnt1, rom_addr}, {2'b10, 8'h44});
    else passed++;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    total++;
    if ({rvalid0, rdata0, rvalid1} !== {1'b1, 8'hE1, 1'b0})
      $display("FAIL rst_wait_next: got %h want %h", {rvalid0, rdata0, rvalid1}, {1'b1, 8'hE1, 1'b0});
    else passed++;
  endtask

  task automatic test_busy_ignored();
    logic prev_en;
    do_reset();
    req0 = 1'b1;
    addr0 = 8'h66;
    tick();
    prev_en = rom_en;
    req0 = 1'b0;
    req1 = 1'b1;
    addr1 = 8'h77;
    tick();
    total++;
    if ({gnt1, rom_en & prev_en, busy} !== 3'b001)
      $display("FAIL busy_wait: got %b want 001", {gnt1, rom_en & prev_en, busy});
    else passed++;
    tick();
    total++;
    if ({gnt1, rom_en, rvalid0, rdata0} !== {3'b001, 8'hC3})
      $display("FAIL busy_idle: got %h want %h", {gnt1, rom_en, rvalid0, rdata0}, {3'b001, 8'hC3});
    else passed++;
    tick();
    total++;
    if ({gnt0, gnt1, rom_en, rom_addr} !== {3'b011, 8'h77})
      $display("FAIL busy_late_gnt: got %h want %h", {gnt0, gnt1, rom_en, rom_addr}, {3'b011, 8'h77});
    else passed++;
    req1 = 1'b0;
    tick();
    total++;
    if (rom_en !== 1'b0)
      $display("FAIL busy_en_consec: got %b want 0", rom_en);
    else passed++;
    tick();
    total++;
    if ({rvalid1, rdata1, rvalid0, rdata0} !== {1'b1, 8'hD2, 1'b0, 8'hC3})
      $display("FAIL busy_rdata1: got %h want %h", {rvalid1, rdata1, rvalid0, rdata0}, {1'b1, 8'hD2, 1'b0, 8'hC3});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_port0();
    test_both();
    test_back_to_back();
    test_reset_wait();
    test_busy_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
